// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and default geometry for the instruction fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int C_XLEN       = 32;
  localparam int C_ORDER_W    = 64;
  localparam int C_LINE_BYTES = 32;
  localparam int C_LINE_OFF   = $clog2(C_LINE_BYTES);
  localparam int C_LINE_WORDS = C_LINE_BYTES / 4;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // Layout of one instruction-queue entry at the default widths
  typedef struct packed {
    logic [C_ORDER_W-1:0] order;
    logic [C_XLEN-1:0]    pc;
    logic [31:0]          instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_line_buffer.sv
// ============================================================================
// Module : fetch_line_buffer
// Brief  : Single-line instruction buffer: fill, invalidate, tag match, word select.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fill,
  input  logic [XLEN-$clog2(LINE_BYTES)-1:0]   fill_tag,
  input  logic [8*LINE_BYTES-1:0]              fill_data,
  input  logic                                 invalidate,
  input  logic [XLEN-$clog2(LINE_BYTES)-1:0]   pc_tag,
  input  logic [$clog2(LINE_BYTES)-3:0]        pc_idx,
  output logic                                 hit,
  output logic [31:0]                          instr
);

  localparam int C_OFF   = $clog2(LINE_BYTES);
  localparam int C_WORDS = LINE_BYTES / 4;
  localparam int C_TAG_W = XLEN - C_OFF;

  logic [8*LINE_BYTES-1:0] r_data;
  logic [C_TAG_W-1:0]      r_tag;
  logic                    r_valid;
  logic [31:0]             w_words [C_WORDS];

  // Invalidate wins over a coincident fill so a fenced line never becomes live
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (invalidate) begin
      r_valid <= 1'b0;
    end else if (fill) begin
      r_valid <= 1'b1;
      r_tag   <= fill_tag;
      r_data  <= fill_data;
    end
  end

  for (genvar gi = 0; gi < C_WORDS; gi++) begin : g_words
    assign w_words[gi] = r_data[gi*32 +: 32];
  end

  assign hit   = r_valid && (pc_tag == r_tag);
  assign instr = w_words[pc_idx];

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : Instruction fetch: PC, order counter, line refill FSM, queue enqueue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                XLEN       = 32,
  parameter int                LINE_BYTES = 32,
  parameter logic [XLEN-1:0]   RESET_PC   = XLEN'('hAAAAA000),
  parameter int                ORDER_W    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            imem_addr,
  output logic [3:0]                 imem_rmask,
  input  logic [8*LINE_BYTES-1:0]    imem_rdata,
  input  logic                       imem_resp,
  output logic [ORDER_W+XLEN+31:0]   iq_data,
  output logic                       iq_enqueue,
  input  logic                       iq_full,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       fence_i,
  output logic [XLEN-1:0]            fetch_pc
);

  localparam int C_OFF = $clog2(LINE_BYTES);

  fetch_state_e         r_state;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_req_addr;
  logic [ORDER_W-1:0]   r_order;

  logic                 w_hit;
  logic [31:0]          w_instr;
  logic                 w_fill;
  logic                 w_enq;

  fetch_line_buffer #(
    .XLEN       (XLEN),
    .LINE_BYTES (LINE_BYTES)
  ) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .fill       (w_fill),
    .fill_tag   (r_req_addr[XLEN-1:C_OFF]),
    .fill_data  (imem_rdata),
    .invalidate (fence_i),
    .pc_tag     (r_pc[XLEN-1:C_OFF]),
    .pc_idx     (r_pc[C_OFF-1:2]),
    .hit        (w_hit),
    .instr      (w_instr)
  );

  // A response that coincides with fence_i is stale and must not be installed
  assign w_fill = (r_state == ST_WAIT) && imem_resp && !fence_i;
  assign w_enq  = !rst && (r_state == ST_RUN) && w_hit && !iq_full && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_order    <= '0;
      r_req_addr <= '0;
    end else begin
      if (w_enq) begin
        r_pc    <= r_pc + XLEN'(4);
        r_order <= r_order + ORDER_W'(1);
      end
      if (redirect) begin
        r_pc <= redirect_pc & ~XLEN'(3);
      end

      case (r_state)
        ST_RUN: begin
          // A redirect retargets the PC, so a miss on the old PC is not worth fetching
          if (!w_hit && !redirect) begin
            r_req_addr <= {r_pc[XLEN-1:C_OFF], {C_OFF{1'b0}}};
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp) begin
            r_state <= ST_RUN;
          end else if (fence_i) begin
            r_state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (imem_resp) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign imem_addr  = r_req_addr;
  assign imem_rmask = (r_state != ST_RUN) ? 4'hF : 4'h0;
  assign iq_enqueue = w_enq;
  assign iq_data    = w_enq ? {r_order, r_pc, w_instr} : '0;
  assign fetch_pc   = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Directed, table-driven checks of fetch_stage at default parameters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  imem_addr;
  logic [3:0]   imem_rmask;
  logic [255:0] imem_rdata;
  logic         imem_resp;
  logic [127:0] iq_data;
  logic         iq_enqueue;
  logic         iq_full;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         fence_i;
  logic [31:0]  fetch_pc;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_rdata  (imem_rdata),
    .imem_resp   (imem_resp),
    .iq_data     (iq_data),
    .iq_enqueue  (iq_enqueue),
    .iq_full     (iq_full),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fence_i     (fence_i),
    .fetch_pc    (fetch_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        full;
    logic        redir;
    logic [31:0] rpc;
    logic        fence;
    logic        resp;
    logic [31:0] dbase;
    logic        enq;
    logic [31:0] pc;
    logic [63:0] order;
    logic [31:0] instr;
    logic [3:0]  rmask;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(logic full, logic redir, logic [31:0] rpc, logic fence,
                              logic resp, logic [31:0] dbase, logic enq, logic [31:0] pc,
                              logic [63:0] order, logic [31:0] instr, logic [3:0] rmask,
                              logic [31:0] addr);
    vec_t v;
    v.full = full; v.redir = redir; v.rpc = rpc; v.fence = fence;
    v.resp = resp; v.dbase = dbase; v.enq = enq; v.pc = pc;
    v.order = order; v.instr = instr; v.rmask = rmask; v.addr = addr;
    return v;
  endfunction

  function automatic logic [255:0] make_line(logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one vector for one cycle, compare outputs, then advance past the edge
  task automatic run_vec(vec_t v, string tag);
    fetch_entry_t e;
    iq_full     = v.full;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    fence_i     = v.fence;
    imem_resp   = v.resp;
    imem_rdata  = v.resp ? make_line(v.dbase) : '0;
    #2;
    e = fetch_entry_t'(iq_data);
    chk({tag, ".enq"}, 64'(iq_enqueue), 64'(v.enq));
    chk({tag, ".fetch_pc"}, 64'(fetch_pc), 64'(v.pc));
    chk({tag, ".rmask"}, 64'(imem_rmask), 64'(v.rmask));
    if (v.rmask == 4'hF) chk({tag, ".imem_addr"}, 64'(imem_addr), 64'(v.addr));
    if (v.enq) begin
      chk({tag, ".order"}, e.order, v.order);
      chk({tag, ".q_pc"}, 64'(e.pc), 64'(v.pc));
      chk({tag, ".instr"}, 64'(e.instr), 64'(v.instr));
    end else begin
      chk({tag, ".iq_data_zero"}, iq_data[127:64] | iq_data[63:0], 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iq_full = 1'b0; redirect = 1'b0; redirect_pc = '0;
    fence_i = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.enq", 64'(iq_enqueue), 64'd0);
    chk("reset.rmask", 64'(imem_rmask), 64'd0);
    chk("reset.fetch_pc", 64'(fetch_pc), 64'hAAAAA000);
    chk("reset.iq_data", iq_data[127:64] | iq_data[63:0], 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Cold start, first line, back-pressure, then crossing into the next line
    tbl[0]  = mk(0, 0, 0, 0, 0, 0,       0, 32'hAAAAA000, 0, 0, 4'h0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 32'h1000, 0, 32'hAAAAA000, 0, 0, 4'hF, 32'hAAAAA000);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,       1, 32'hAAAAA000, 0, 32'h1000, 4'h0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,       1, 32'hAAAAA004, 1, 32'h1001, 4'h0, 0);
    for (int k = 0; k < 3; k++)
      tbl[4+k] = mk(1, 0, 0, 0, 0, 0, 0, 32'hAAAAA008, 0, 0, 4'h0, 0);
    for (int k = 0; k < 6; k++)
      tbl[7+k] = mk(0, 0, 0, 0, 0, 0, 1, 32'hAAAAA008 + 32'(4*k), 64'(2+k),
                    32'h1002 + 32'(k), 4'h0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,       0, 32'hAAAAA020, 0, 0, 4'h0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,       0, 32'hAAAAA020, 0, 0, 4'hF, 32'hAAAAA020);

    do_reset();
    for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Redirect during WAIT: old request held, stale line installed, then re-miss
    do_reset();
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAAA000, 0, 0, 4'h0, 0), "redir.c0");
    run_vec(mk(0, 1, 32'hAAAAB004, 0, 0, 0, 0, 32'hAAAAA000, 0, 0, 4'hF, 32'hAAAAA000), "redir.c1");
    run_vec(mk(0, 0, 0, 0, 1, 32'h2000, 0, 32'hAAAAB004, 0, 0, 4'hF, 32'hAAAAA000), "redir.c2");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAAB004, 0, 0, 4'h0, 0), "redir.c3");
    run_vec(mk(0, 0, 0, 0, 1, 32'h3000, 0, 32'hAAAAB004, 0, 0, 4'hF, 32'hAAAAB000), "redir.c4");
    run_vec(mk(0, 0, 0, 0, 0, 0, 1, 32'hAAAAB004, 0, 32'h3001, 4'h0, 0), "redir.c5");

    // fence_i during WAIT: DROP discards the response, same line re-requested
    run_vec(mk(0, 1, 32'hAAAAC000, 0, 0, 0, 0, 32'hAAAAB008, 0, 0, 4'h0, 0), "fence.c6");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAAC000, 0, 0, 4'h0, 0), "fence.c7");
    run_vec(mk(0, 0, 0, 1, 0, 0, 0, 32'hAAAAC000, 0, 0, 4'hF, 32'hAAAAC000), "fence.c8");
    run_vec(mk(0, 0, 0, 0, 1, 32'h4000, 0, 32'hAAAAC000, 0, 0, 4'hF, 32'hAAAAC000), "fence.c9");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'hAAAAC000, 0, 0, 4'h0, 0), "fence.c10");
    run_vec(mk(0, 0, 0, 0, 1, 32'h5000, 0, 32'hAAAAC000, 0, 0, 4'hF, 32'hAAAAC000), "fence.c11");
    run_vec(mk(0, 0, 0, 0, 0, 0, 1, 32'hAAAAC000, 1, 32'h5000, 4'h0, 0), "fence.c12");

    // PC wrap at the top of the address space; low redirect bits are cleared
    run_vec(mk(0, 1, 32'hFFFFFFFE, 0, 0, 0, 0, 32'hAAAAC004, 0, 0, 4'h0, 0), "wrap.c13");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 4'h0, 0), "wrap.c14");
    run_vec(mk(0, 0, 0, 0, 1, 32'h6000, 0, 32'hFFFFFFFC, 0, 0, 4'hF, 32'hFFFFFFE0), "wrap.c15");
    run_vec(mk(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFC, 2, 32'h6007, 4'h0, 0), "wrap.c16");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0, 4'h0, 0), "wrap.c17");
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0, 4'hF, 32'h00000000), "wrap.c18");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
